// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - parametrised register file with write bypass, optional zero register and pending scoreboard
module register_file_sb #(
  parameter int DATA_W   = 20,
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          write,
  input  logic [ADDR_W-1:0]          w_select,
  input  logic                       w,
  input  logic [NUM_RD*ADDR_W-1:0]   r_select,
  output logic [NUM_RD*DATA_W-1:0]   read,
  input  logic                       claim,
  input  logic [ADDR_W-1:0]          claim_select,
  output logic [NUM_RD-1:0]          r_pending,
  output logic [(2**ADDR_W)-1:0]     pending_vec
);

  localparam int DEPTH = 2**ADDR_W;
  localparam bit BYP   = (BYPASS != 0);
  localparam bit ZREG  = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pending_nxt;
  logic              wr_en;

  assign wr_en = w && !(ZREG && (w_select == '0));

  // Claim is applied after the write clear so a same-cycle new producer keeps the entry pending.
  always_comb begin
    pending_nxt = pending;
    if (w) pending_nxt[w_select] = 1'b0;
    if (claim) pending_nxt[claim_select] = 1'b1;
    if (ZREG) pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pending <= '0;
    end else begin
      if (wr_en) regs[w_select] <= write;
      pending <= pending_nxt;
    end
  end

  // Forwarding is gated by reset so a write being discarded by reset is never visible.
  always_comb begin
    logic [ADDR_W-1:0] s;
    logic              fwd;
    read      = '0;
    r_pending = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      s   = r_select[k*ADDR_W +: ADDR_W];
      fwd = BYP && reset && w && (w_select == s);
      if (ZREG && (s == '0)) begin
        read[k*DATA_W +: DATA_W] = '0;
        r_pending[k]             = 1'b0;
      end else begin
        read[k*DATA_W +: DATA_W] = fwd ? write : regs[s];
        r_pending[k]             = pending[s] && !fwd;
      end
    end
  end

  assign pending_vec = pending;

endmodule

// File: tb/tb_register_file_sb.sv
// tb/tb_register_file_sb.sv - self-checking bench for register_file_sb
module tb_register_file_sb;
  localparam int DW = 20;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int NA = 4;
  localparam int NB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, w, claim;
  logic [DW-1:0] write;
  logic [AW-1:0] w_select, claim_select;
  logic [NA*AW-1:0] rsel_a;
  logic [NA*DW-1:0] read_a;
  logic [NA-1:0]    rpend_a;
  logic [DEPTH-1:0] pvec_a;
  logic [NB*AW-1:0] rsel_b;
  logic [NB*DW-1:0] read_b;
  logic [NB-1:0]    rpend_b;
  logic [DEPTH-1:0] pvec_b;

  // a: bypass on, no zero register, four ports; b: bypass off, zero register, two ports
  register_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NA), .BYPASS(1), .ZERO_REG(0)) dut_a (
    .clk(clk), .reset(reset), .write(write), .w_select(w_select), .w(w),
    .r_select(rsel_a), .read(read_a), .claim(claim), .claim_select(claim_select),
    .r_pending(rpend_a), .pending_vec(pvec_a));

  register_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NB), .BYPASS(0), .ZERO_REG(1)) dut_b (
    .clk(clk), .reset(reset), .write(write), .w_select(w_select), .w(w),
    .r_select(rsel_b), .read(read_b), .claim(claim), .claim_select(claim_select),
    .r_pending(rpend_b), .pending_vec(pvec_b));

  logic [DW-1:0]    mem [2][DEPTH];
  logic [DEPTH-1:0] pend [2];
  int checks = 0;
  int failures = 0;

  function automatic logic [DW-1:0] m_read(int c, logic [AW-1:0] s);
    if (c == 1 && s == 0) return '0;
    if (c == 0 && reset && w && w_select == s) return write;
    return mem[c][s];
  endfunction

  function automatic logic m_rpend(int c, logic [AW-1:0] s);
    if (c == 1 && s == 0) return 1'b0;
    if (c == 0 && reset && w && w_select == s) return 1'b0;
    return pend[c][s];
  endfunction

  task automatic model_edge();
    for (int c = 0; c < 2; c++) begin
      if (!reset) begin
        for (int i = 0; i < DEPTH; i++) mem[c][i] = '0;
        pend[c] = '0;
      end else begin
        if (w && !(c == 1 && w_select == 0)) mem[c][w_select] = write;
        if (w) pend[c][w_select] = 1'b0;
        if (claim && !(c == 1 && claim_select == 0)) pend[c][claim_select] = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int k = 0; k < NA; k++) begin
      chk($sformatf("%s.a.read%0d", tag, k), read_a[k*DW +: DW], m_read(0, rsel_a[k*AW +: AW]));
      chk($sformatf("%s.a.rpend%0d", tag, k), rpend_a[k], m_rpend(0, rsel_a[k*AW +: AW]));
    end
    chk($sformatf("%s.a.pvec", tag), pvec_a, pend[0]);
    for (int k = 0; k < NB; k++) begin
      chk($sformatf("%s.b.read%0d", tag, k), read_b[k*DW +: DW], m_read(1, rsel_b[k*AW +: AW]));
      chk($sformatf("%s.b.rpend%0d", tag, k), rpend_b[k], m_rpend(1, rsel_b[k*AW +: AW]));
    end
    chk($sformatf("%s.b.pvec", tag), pvec_b, pend[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] s);
    rsel_a[k*AW +: AW] = s;
    if (k < NB) rsel_b[k*AW +: AW] = s;
  endtask

  task automatic idle();
    w = 1'b0; claim = 1'b0; write = '0; w_select = '0; claim_select = '0;
  endtask

  initial begin
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < DEPTH; i++) mem[c][i] = '0;
      pend[c] = '0;
    end
    reset = 1'b0; rsel_a = '0; rsel_b = '0;
    idle();
    tick(); tick();
    reset = 1'b1;
    settle();
    chk("reset.read0", read_a[0 +: DW], 0);
    chk("reset.pvec_a", pvec_a, 0);
    chk("reset.rpend_a", rpend_a, 0);
    check_outputs("reset");

    w = 1'b1; w_select = 4'd0; write = 20'd123; tick();
    w_select = 4'd1; write = 20'd1234; tick();
    w_select = 4'd2; write = 20'd12345; tick();
    idle();
    set_rd(0, 4'd0); set_rd(1, 4'd1);
    settle();
    chk("plain.read0", read_a[0 +: DW], 123);
    chk("plain.read1", read_a[DW +: DW], 1234);
    check_outputs("plain");

    w = 1'b0; w_select = 4'd3; write = 20'd111; tick();
    set_rd(0, 4'd3);
    settle();
    chk("nowrite.r3", read_a[0 +: DW], 0);

    w = 1'b1; w_select = 4'd5; write = 20'd777; set_rd(0, 4'd5);
    settle();
    chk("bypass.a", read_a[0 +: DW], 777);
    chk("bypass.b_old", read_b[0 +: DW], 0);
    check_outputs("bypass");
    tick(); idle();

    claim = 1'b1; claim_select = 4'd7; set_rd(1, 4'd7);
    settle();
    chk("claim.same_cycle", pvec_a[7], 0);
    tick(); idle();
    settle();
    chk("claim.pvec7", pvec_a[7], 1);
    chk("claim.rpend", rpend_a[1], 1);
    w = 1'b1; w_select = 4'd7; write = 20'd42;
    settle();
    chk("wb.rpend_bypass", rpend_a[1], 0);
    chk("wb.rpend_nobypass", rpend_b[1], 1);
    check_outputs("wb");
    tick(); idle();
    settle();
    chk("wb.pvec7", pvec_a[7], 0);
    chk("wb.read7", read_a[DW +: DW], 42);

    claim = 1'b1; claim_select = 4'd4; w = 1'b1; w_select = 4'd4; write = 20'd9;
    tick(); idle(); set_rd(0, 4'd4);
    settle();
    chk("collide.read", read_a[0 +: DW], 9);
    chk("collide.pvec4", pvec_a[4], 1);
    check_outputs("collide");

    w = 1'b1; w_select = 4'd0; write = 20'd55; claim = 1'b1; claim_select = 4'd0;
    tick(); idle(); set_rd(0, 4'd0);
    settle();
    chk("zero.b_read", read_b[0 +: DW], 0);
    chk("zero.b_pvec0", pvec_b[0], 0);
    chk("zero.a_read", read_a[0 +: DW], 55);
    chk("zero.a_pvec0", pvec_a[0], 1);

    for (int k = 0; k < NA; k++) set_rd(k, 4'd2);
    settle();
    for (int k = 0; k < NA; k++) chk($sformatf("multi.read%0d", k), read_a[k*DW +: DW], 12345);

    w = 1'b1; w_select = 4'd3; write = 20'd99; claim = 1'b1; claim_select = 4'd3;
    tick(); idle(); set_rd(0, 4'd3);
    settle();
    chk("mid.pre_read", read_a[0 +: DW], 99);
    chk("mid.pre_pend", pvec_a[3], 1);
    reset = 1'b0; w = 1'b1; w_select = 4'd3; write = 20'd500;
    settle();
    chk("mid.no_bypass_in_reset", read_a[0 +: DW], 99);
    check_outputs("mid.inreset");
    tick(); reset = 1'b1; idle();
    settle();
    chk("mid.read3", read_a[0 +: DW], 0);
    chk("mid.pvec_a", pvec_a, 0);
    chk("mid.pvec_b", pvec_b, 0);

    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) != 0);
      w = $urandom_range(0, 1);
      claim = ($urandom_range(0, 2) == 0);
      write = DW'($urandom);
      w_select = AW'($urandom);
      claim_select = AW'($urandom);
      for (int k = 0; k < NA; k++) set_rd(k, AW'($urandom));
      settle();
      check_outputs($sformatf("rand%0d", n));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
- Parametrised successor to the 16x20 single-write/dual-read register file.
- Adds a configurable number of read ports, optional write-to-read bypass, an optional hardwired zero register, and a per-register pending scoreboard.
- Sits between decode (issues claims and reads) and writeback (performs writes). Decode uses the pending flags to detect RAW hazards and stall.

Parameters:
- DATA_W, 20, register width in bits.
- ADDR_W, 4, select width; depth = 2**ADDR_W registers.
- NUM_RD, 2, number of read ports (1..8).
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = reads show stored value only.
- ZERO_REG, 0, 1 = register 0 reads as 0, ignores writes and never becomes pending.

Ports:
- clk  in  1  rising-edge clock, sole clock.
- reset  in  1  synchronous, active-low reset (sampled on rising clk edge when 0).
- write  in  DATA_W  write data.
- w_select  in  ADDR_W  write address.
- w  in  1  write enable.
- r_select  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
- read  out  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W].
- claim  in  1  mark register claim_select pending (result outstanding).
- claim_select  in  ADDR_W  register to claim.
- r_pending  out  NUM_RD  bit k = register addressed by read port k is pending.
- pending_vec  out  2**ADDR_W  full scoreboard state.

Behaviour:
- Storage: 2**ADDR_W x DATA_W registers plus a 2**ADDR_W pending bit vector. All updates occur on the rising clk edge.
- Reset (reset==0 at an edge): all registers become 0 and all pending bits are cleared. Reset overrides w and claim in the same cycle. Reset mid-operation discards any outstanding claims.
- While reset==0, bypass is suppressed and reads show stored contents.
- Write: if w==1, write is stored to w_select at the edge and the pending bit of w_select is cleared. A write to a non-pending register is legal.
- Claim: if claim==1, the pending bit of claim_select is set at the edge.
- Simultaneous claim and write to the same register: data is stored and the pending bit ends at 1 (new producer wins).
- Simultaneous claim and write to different registers: both take effect independently.
- Reads are combinational (0-cycle latency), with no restriction on aliasing between ports. For port k with address s:
  - if ZERO_REG and s==0, the port reads 0;
  - else if BYPASS, reset==1, w==1 and w_select==s, the port reads write;
  - otherwise the port reads the stored value of s.
- r_pending[k] = pending[s] & ~(BYPASS & reset & w & w_select==s). It is forced to 0 when ZERO_REG and s==0.
- A claim issued this cycle does not affect r_pending or pending_vec until the next cycle.
- pending_vec is the registered pending vector, with no bypass applied.
- ZERO_REG=1:
  - writes to 0 are discarded (the write is still forwarded nowhere);
  - claims to 0 are ignored;
  - pending_vec[0] is always 0.
- After reset: every read is 0, r_pending = 0 and pending_vec = 0.
- Out-of-range parameter values (NUM_RD outside 1..8) are not supported and need not be checked.

Test Plan:
- Reset then plain write/read: defaults; write 123 to r0, then 1234 to r1 and 12345 to r2 on successive cycles; read r0/r1 on the next cycle -> read0=123, read1=1234. With w=0 and write=111 to r3, r3 stays 0.
- Bypass: BYPASS=1; in the same cycle w=1, w_select=5, write=777, r_select0=5 -> read0=777 before the edge. Repeat with BYPASS=0 -> read0 shows the old value (0).
- Scoreboard: claim r7 -> next cycle pending_vec[7]=1 and r_pending on a port reading r7 =1. Write 42 to r7 -> r_pending=0 in that cycle (BYPASS=1), pending_vec[7]=0 after the edge, read r7=42.
- Claim/write collision: claim r4 and write 9 to r4 in the same cycle -> after the edge r4=9 and pending_vec[4]=1.
- Zero register: ZERO_REG=1; write 55 to r0 and claim r0 -> read r0=0 and pending_vec[0]=0. Multi-port: NUM_RD=4, all ports select r2 holding 12345 -> all four reads =12345.
- Reset mid-operation: with r3=99 and r3 pending, assert reset=0 for one edge while w=1 targets r3 -> r3=0, pending_vec all 0, and the write is lost.
